// File: rtl/button_count_pkg.sv
// Shared types and constants for the button-driven 0..3 counter that feeds the
// seven-segment decoder.
package button_count_pkg;

   typedef enum logic {
      COUNT = 1'b0,
      ERROR = 1'b1
   } state_t;

   localparam logic [2:0] ERR_CODE  = 3'b100;
   localparam logic [1:0] MAX_COUNT = 2'd3;

   // Counter must be able to hold DEBOUNCE_CYCLES itself.
   function automatic int debounce_cnt_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchronizer, stable-time debouncer and a
// registered rising-edge detector producing a one-cycle press pulse.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press
);
   import button_count_pkg::*;

   localparam int               CNT_W   = debounce_cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic             raw_in;
   logic             sync_q1;
   logic             sync_q2;
   logic             level_d;
   logic [CNT_W-1:0] cnt;

   assign raw_in = BTN_ACTIVE_LOW ? ~raw : raw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
         press   <= 1'b0;
      end else begin
         sync_q1 <= raw_in;
         sync_q2 <= sync_q1;
         // Accept the new level only after it has differed for DEBOUNCE_CYCLES
         // consecutive cycles; any return to the accepted level restarts the count.
         if (sync_q2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            level <= sync_q2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         level_d <= level;
         press   <= level & ~level_d;
      end
   end

endmodule

// File: rtl/button_count_ctrl.sv
// Three debounced buttons drive a 0..3 counter with a sticky error code; the
// registered 3-bit code goes straight to the seven-segment decoder.
module button_count_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_up_raw,
   input  logic       btn_down_raw,
   input  logic       btn_clr_raw,
   output logic [2:0] code,
   output logic       err,
   output logic       step
);
   import button_count_pkg::*;

   logic [2:0] btn_level_unused;
   logic       up_p;
   logic       dn_p;
   logic       clr_p;
   state_t     state;
   logic [1:0] count;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)) u_up (
      .clk(clk), .rst_n(rst_n), .raw(btn_up_raw), .level(btn_level_unused[0]), .press(up_p)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)) u_down (
      .clk(clk), .rst_n(rst_n), .raw(btn_down_raw), .level(btn_level_unused[1]), .press(dn_p)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)) u_clr (
      .clk(clk), .rst_n(rst_n), .raw(btn_clr_raw), .level(btn_level_unused[2]), .press(clr_p)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= COUNT;
         count <= 2'd0;
         code  <= 3'b000;
         err   <= 1'b0;
         step  <= 1'b0;
      end else begin
         step <= 1'b0;
         if (clr_p) begin
            state <= COUNT;
            count <= 2'd0;
            code  <= 3'b000;
            err   <= 1'b0;
            step  <= (code != 3'b000);
         end else if (up_p ^ dn_p) begin
            // up+down together cancel; a lone press only acts while counting.
            case (state)
               COUNT: begin
                  if (up_p) begin
                     if (count == MAX_COUNT) begin
                        state <= ERROR;
                        code  <= ERR_CODE;
                        err   <= 1'b1;
                     end else begin
                        count <= count + 2'd1;
                        code  <= {1'b0, count + 2'd1};
                     end
                  end else begin
                     if (count == 2'd0) begin
                        state <= ERROR;
                        code  <= ERR_CODE;
                        err   <= 1'b1;
                     end else begin
                        count <= count - 2'd1;
                        code  <= {1'b0, count - 2'd1};
                     end
                  end
                  step <= 1'b1;
               end
               ERROR: begin
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule
